// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and fault check for the data-memory responder
package dmem_pkg;

    // Access size, taken from funct3[1:0]
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Byte offsets inside the 256-byte MMIO window
    localparam logic [7:0] OFF_CYCLE  = 8'h00;
    localparam logic [7:0] OFF_TOHOST = 8'h04;
    localparam logic [7:0] OFF_FAULT  = 8'h08;

    // True when an access of this size/alignment/target must be refused.
    // The caller qualifies it with the read/write strobes.
    function automatic logic access_fault(
        input logic [1:0] size,
        input logic       misalign,
        input logic       ram_hit,
        input logic       mmio_hit
    );
        return (size == 2'b11)
            || misalign
            || !(ram_hit || mmio_hit)
            || (mmio_hit && (size != SZ_W));
    endfunction

endpackage

// File: rtl/store_lanes.sv
// rtl/store_lanes.sv - store byte-enable, lane replication and alignment check
//
// Ports:
//   addr     in  2   low address bits of the store
//   funct3   in  3   access size in [1:0]; [2] (unsigned-load flag) has no store meaning
//   wd       in  32  unshifted store data
//   be       out 4   byte enables; all zero for the illegal size
//   wdata    out 32  store data replicated onto every candidate lane
//   misalign out 1   half on an odd address or word not on a 4-byte boundary
module store_lanes
    import dmem_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] wd,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign
);

    logic unused_funct3;
    assign unused_funct3 = funct3[2];

    always_comb begin
        be       = 4'b0000;
        wdata    = wd;
        misalign = 1'b0;
        case (funct3[1:0])
            SZ_B: begin
                be    = 4'b0001 << addr;
                wdata = {4{wd[7:0]}};
            end
            SZ_H: begin
                be       = 4'b0011 << {addr[1], 1'b0};
                wdata    = {2{wd[15:0]}};
                misalign = addr[0];
            end
            SZ_W: begin
                be       = 4'b1111;
                misalign = |addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: word RAM plus cycle/tohost/fault MMIO
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   memwriteM      store request this cycle
//   memreadM       load request this cycle (only gates fault checks)
//   addrM          byte address
//   writedataM     unshifted store data
//   funct3M        access size in [1:0]
//   readdataM      raw aligned word at addrM, combinational; 0 for a faulting access
//   fault          sticky access fault, cleared by a write to the FAULT register
//   fault_addr     address of the most recent fault
//   tohost_valid   one-cycle pulse after each tohost write
//   tohost_data    last value written to tohost
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          DEPTH     = 256,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00,
    parameter string       INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             memwriteM,
    input  logic             memreadM,
    input  logic [WIDTH-1:0] addrM,
    input  logic [WIDTH-1:0] writedataM,
    input  logic [2:0]       funct3M,
    output logic [WIDTH-1:0] readdataM,
    output logic             fault,
    output logic [WIDTH-1:0] fault_addr,
    output logic             tohost_valid,
    output logic [WIDTH-1:0] tohost_data
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

    logic [31:0]   mem [DEPTH];

    logic [31:0]   counter;
    logic          ram_hit;
    logic          mmio_hit;
    logic [AW-1:0] ram_idx;
    logic [7:0]    mmio_off;
    logic [3:0]    be;
    logic [31:0]   lane_data;
    logic          misalign;
    logic          acc_fault;
    logic          ram_we;
    logic          tohost_wr;
    logic          fault_clr;

    store_lanes u_lanes (
        .addr     (addrM[1:0]),
        .funct3   (funct3M),
        .wd       (writedataM),
        .be       (be),
        .wdata    (lane_data),
        .misalign (misalign)
    );

    assign ram_hit  = addrM < RAM_BYTES;
    assign mmio_hit = addrM[31:8] == MMIO_BASE[31:8];
    assign ram_idx  = addrM[AW+1:2];
    assign mmio_off = addrM[7:0];

    // Fault checks only apply to real requests; an idle address is just decoded.
    assign acc_fault = (memwriteM || memreadM)
                     && access_fault(funct3M[1:0], misalign, ram_hit, mmio_hit);

    // rst suppresses a same-cycle store so reset leaves RAM untouched.
    assign ram_we    = memwriteM && !rst && ram_hit && !acc_fault;
    assign tohost_wr = memwriteM && mmio_hit && !acc_fault && (mmio_off == OFF_TOHOST);
    assign fault_clr = memwriteM && mmio_hit && !acc_fault && (mmio_off == OFF_FAULT);

    always_comb begin
        readdataM = '0;
        if (ram_hit) begin
            readdataM = mem[ram_idx];
        end else if (mmio_hit) begin
            case (mmio_off)
                OFF_CYCLE:  readdataM = counter;
                OFF_TOHOST: readdataM = tohost_data;
                OFF_FAULT:  readdataM = {31'b0, fault};
                default:    readdataM = '0;
            endcase
        end
        if (acc_fault) begin
            readdataM = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[ram_idx][8*b +: 8] <= lane_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter      <= '0;
            fault        <= 1'b0;
            fault_addr   <= '0;
            tohost_valid <= 1'b0;
            tohost_data  <= '0;
        end else begin
            counter      <= counter + 32'd1;
            tohost_valid <= tohost_wr;
            if (tohost_wr) begin
                tohost_data <= writedataM;
            end
            // A clear and a fault cannot coincide: the clear is itself a legal access.
            if (acc_fault) begin
                fault      <= 1'b1;
                fault_addr <= addrM;
            end else if (fault_clr) begin
                fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed vector bench for dmem_responder
module tb_dmem_responder;

    localparam logic [31:0] MMIO = 32'hFFFF_FF00;

    logic        clk;
    logic        rst;
    logic        memwriteM;
    logic        memreadM;
    logic [31:0] addrM;
    logic [31:0] writedataM;
    logic [2:0]  funct3M;
    logic [31:0] readdataM;
    logic        fault;
    logic [31:0] fault_addr;
    logic        tohost_valid;
    logic [31:0] tohost_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] tb_cyc;

    dmem_responder #(
        .WIDTH     (32),
        .DEPTH     (256),
        .MMIO_BASE (MMIO),
        .INIT_FILE ("")
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .memwriteM    (memwriteM),
        .memreadM     (memreadM),
        .addrM        (addrM),
        .writedataM   (writedataM),
        .funct3M      (funct3M),
        .readdataM    (readdataM),
        .fault        (fault),
        .fault_addr   (fault_addr),
        .tohost_valid (tohost_valid),
        .tohost_data  (tohost_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle count: cleared by every reset edge, +1 on every other edge
    always @(posedge clk) tb_cyc <= rst ? 32'd0 : tb_cyc + 32'd1;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic        chk_rd;
        logic [31:0] rd;
        logic        flt;
        logic [31:0] faddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic re, logic [31:0] addr, logic [31:0] wd,
                                logic [2:0] f3, logic chk_rd, logic [31:0] rd,
                                logic flt, logic [31:0] faddr);
        vec_t v;
        v.we = we; v.re = re; v.addr = addr; v.wd = wd; v.f3 = f3;
        v.chk_rd = chk_rd; v.rd = rd; v.flt = flt; v.faddr = faddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [2:0] f3);
        memwriteM  = we;
        memreadM   = re;
        addrM      = addr;
        writedataM = wd;
        funct3M    = f3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] c0;

    initial begin
        // Store/load/fault vectors; fault state listed is the value after the edge
        vecs.push_back(mk(1, 0, 32'h10, 32'h11223344, 3'b010, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h12, 32'h0, 3'b000, 1, 32'h11223344, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h13, 32'hAB, 3'b000, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h10, 32'h0, 3'b010, 1, 32'hAB223344, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h12, 32'hBEEF, 3'b001, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h10, 32'h0, 3'b010, 1, 32'hBEEF3344, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h10, 32'hCAFEF00D, 3'b010, 1, 32'hBEEF3344, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h10, 32'h0, 3'b010, 1, 32'hCAFEF00D, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h100, 32'h55667788, 3'b010, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h102, 32'hDEADBEEF, 3'b010, 1, 32'h0, 1, 32'h102));
        vecs.push_back(mk(0, 0, 32'h100, 32'h0, 3'b010, 1, 32'h55667788, 1, 32'h102));
        vecs.push_back(mk(0, 1, MMIO + 8, 32'h0, 3'b010, 1, 32'h1, 1, 32'h102));
        vecs.push_back(mk(1, 0, MMIO + 8, 32'h0, 3'b010, 0, 0, 0, 32'h102));
        vecs.push_back(mk(0, 1, 32'h8000_0000, 32'h0, 3'b010, 1, 32'h0, 1, 32'h8000_0000));
        vecs.push_back(mk(1, 0, MMIO + 8, 32'h0, 3'b010, 0, 0, 0, 32'h8000_0000));
        vecs.push_back(mk(1, 0, 32'h11, 32'h1234, 3'b001, 1, 32'h0, 1, 32'h11));
        vecs.push_back(mk(0, 0, 32'h10, 32'h0, 3'b010, 1, 32'hCAFEF00D, 1, 32'h11));
        vecs.push_back(mk(1, 0, MMIO + 8, 32'h0, 3'b010, 0, 0, 0, 32'h11));
        vecs.push_back(mk(0, 1, 32'h10, 32'h0, 3'b011, 1, 32'h0, 1, 32'h10));
        vecs.push_back(mk(1, 0, MMIO + 8, 32'h0, 3'b010, 0, 0, 0, 32'h10));
        vecs.push_back(mk(0, 1, MMIO, 32'h0, 3'b000, 1, 32'h0, 1, MMIO));
        vecs.push_back(mk(1, 0, MMIO + 8, 32'h0, 3'b010, 0, 0, 0, MMIO));
        vecs.push_back(mk(0, 1, MMIO + 8, 32'h0, 3'b010, 1, 32'h0, 0, MMIO));
        vecs.push_back(mk(1, 0, MMIO, 32'h5, 3'b010, 0, 0, 0, MMIO));
        vecs.push_back(mk(1, 0, MMIO + 32'h10, 32'h9, 3'b010, 0, 0, 0, MMIO));
        vecs.push_back(mk(0, 1, MMIO + 32'h10, 32'h0, 3'b010, 1, 32'h0, 0, MMIO));
        vecs.push_back(mk(0, 1, 32'h12, 32'h0, 3'b101, 1, 32'hCAFEF00D, 0, MMIO));
        vecs.push_back(mk(1, 0, 32'h3FC, 32'h0BADCAFE, 3'b010, 0, 0, 0, MMIO));
        vecs.push_back(mk(0, 1, 32'h3FC, 32'h0, 3'b010, 1, 32'h0BADCAFE, 0, MMIO));
        vecs.push_back(mk(0, 1, 32'h400, 32'h0, 3'b010, 1, 32'h0, 1, 32'h400));
        vecs.push_back(mk(0, 0, 32'h13, 32'h0, 3'b001, 1, 32'hCAFEF00D, 1, 32'h400));

        // Reset
        rst = 1'b1;
        drive(0, 0, MMIO, 32'h0, 3'b010);
        tick();
        tick();
        chk("reset fault", {31'b0, fault}, 32'h0);
        chk("reset fault_addr", fault_addr, 32'h0);
        chk("reset tohost_valid", {31'b0, tohost_valid}, 32'h0);
        chk("reset tohost_data", tohost_data, 32'h0);
        chk("reset cycle", readdataM, 32'h0);
        rst = 1'b0;

        // Table
        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wd, vecs[i].f3);
            @(negedge clk);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d readdata", i), readdataM, vecs[i].rd);
            tick();
            chk($sformatf("vec%0d fault", i), {31'b0, fault}, {31'b0, vecs[i].flt});
            chk($sformatf("vec%0d fault_addr", i), fault_addr, vecs[i].faddr);
        end

        // Clear the fault left by the table
        drive(1, 0, MMIO + 8, 32'h0, 3'b010);
        tick();
        chk("clear fault", {31'b0, fault}, 32'h0);

        // Single tohost write: one-cycle pulse
        drive(1, 0, MMIO + 4, 32'h1, 3'b010);
        @(negedge clk);
        chk("tohost before edge", {31'b0, tohost_valid}, 32'h0);
        tick();
        chk("tohost pulse", {31'b0, tohost_valid}, 32'h1);
        chk("tohost data", tohost_data, 32'h1);
        drive(0, 0, 32'h0, 32'h0, 3'b010);
        tick();
        chk("tohost pulse end", {31'b0, tohost_valid}, 32'h0);
        chk("tohost data held", tohost_data, 32'h1);

        // Back-to-back tohost writes
        drive(1, 0, MMIO + 4, 32'h2, 3'b010);
        tick();
        chk("b2b valid 1", {31'b0, tohost_valid}, 32'h1);
        chk("b2b data 1", tohost_data, 32'h2);
        drive(1, 0, MMIO + 4, 32'h3, 3'b010);
        tick();
        chk("b2b valid 2", {31'b0, tohost_valid}, 32'h1);
        chk("b2b data 2", tohost_data, 32'h3);
        drive(0, 0, MMIO + 4, 32'h0, 3'b010);
        tick();
        chk("b2b valid end", {31'b0, tohost_valid}, 32'h0);
        chk("tohost readback", readdataM, 32'h3);

        // Cycle counter: absolute value and consecutive difference
        drive(0, 1, MMIO, 32'h0, 3'b010);
        #1;
        chk("cycle absolute", readdataM, tb_cyc);
        c0 = readdataM;
        tick();
        chk("cycle step", readdataM, c0 + 32'd1);
        chk("cycle absolute 2", readdataM, tb_cyc);

        // Reset coinciding with a store, with state made non-zero first
        drive(1, 0, 32'h20, 32'h12345678, 3'b010);
        tick();
        drive(1, 0, 32'h8000_0000, 32'h0, 3'b010);
        tick();
        chk("pre-reset fault", {31'b0, fault}, 32'h1);
        drive(1, 0, MMIO + 4, 32'h99, 3'b010);
        tick();
        rst = 1'b1;
        drive(1, 0, 32'h20, 32'h77777777, 3'b010);
        tick();
        rst = 1'b0;
        drive(0, 0, 32'h20, 32'h0, 3'b010);
        #1;
        chk("rst store suppressed", readdataM, 32'h12345678);
        chk("rst fault", {31'b0, fault}, 32'h0);
        chk("rst fault_addr", fault_addr, 32'h0);
        chk("rst tohost_valid", {31'b0, tohost_valid}, 32'h0);
        chk("rst tohost_data", tohost_data, 32'h0);
        drive(0, 0, MMIO, 32'h0, 3'b010);
        #1;
        chk("rst counter", readdataM, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
